// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timing engine.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int LAP_NUM = 10;

  // Packed time word: {hh, mm, ss, cc}, one byte per field.
  localparam int FIELD_W = 8;
  localparam int CC_LSB  = 0;
  localparam int SS_LSB  = 8;
  localparam int MM_LSB  = 16;
  localparam int HH_LSB  = 24;

  localparam logic [FIELD_W-1:0] CC_MAX = 8'd99;
  localparam logic [FIELD_W-1:0] SS_MAX = 8'd59;
  localparam logic [FIELD_W-1:0] MM_MAX = 8'd59;
  localparam logic [FIELD_W-1:0] HH_MAX = 8'd99;

  // Next value of a wrapping field counter.
  function automatic logic [FIELD_W-1:0] field_next(input logic [FIELD_W-1:0] value,
                                                   input logic [FIELD_W-1:0] max);
    return (value == max) ? '0 : value + 8'd1;
  endfunction

endpackage

// File: rtl/stopwatch_time_cnt.sv
// Centisecond prescaler plus cascaded cc/ss/mm/hh counters.
module stopwatch_time_cnt
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic        iPCLK,
  input  logic        iPRESETn,
  input  logic        run_i,
  input  logic        clear_i,
  output logic        tick_o,
  output logic [31:0] time_o
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   time_q, time_d;
  logic [FIELD_W-1:0] cc, ss, mm, hh;

  assign cc     = time_q[CC_LSB +: FIELD_W];
  assign ss     = time_q[SS_LSB +: FIELD_W];
  assign mm     = time_q[MM_LSB +: FIELD_W];
  assign hh     = time_q[HH_LSB +: FIELD_W];
  assign tick_o = run_i && (presc_q == PW'(TICK_DIV - 1));
  assign time_o = time_q;

  // Next prescaler phase and next time value; higher fields only move on carry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    presc_d = presc_q;
    time_d  = time_q;
    if (clear_i) begin
      presc_d = '0;
      time_d  = '0;
    end else if (run_i) begin
      presc_d = tick_o ? '0 : presc_q + 1'b1;
      if (tick_o) begin
        time_d[CC_LSB +: FIELD_W] = field_next(cc, CC_MAX);
        if (cc == CC_MAX) begin
          time_d[SS_LSB +: FIELD_W] = field_next(ss, SS_MAX);
          if (ss == SS_MAX) begin
            time_d[MM_LSB +: FIELD_W] = field_next(mm, MM_MAX);
            if (mm == MM_MAX) begin
              time_d[HH_LSB +: FIELD_W] = field_next(hh, HH_MAX);
            end
          end
        end
      end
    end
  end

  // Prescaler and time registers; the prescaler holds its phase while paused.
  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!iPRESETn) begin
      presc_q <= '0;
      time_q  <= '0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch engine: run/pause FSM, lap capture array and lap counter.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic        iPCLK,
  input  logic        iPRESETn,
  input  logic        iWATCH_START,
  input  logic        iWATCH_STOP,
  input  logic        iWATCH_RESET,
  input  logic        iWATCH_STORE,
  output logic [31:0] oCURR_TIME,
  output logic [31:0] oTIME_LAP0,
  output logic [31:0] oTIME_LAP1,
  output logic [31:0] oTIME_LAP2,
  output logic [31:0] oTIME_LAP3,
  output logic [31:0] oTIME_LAP4,
  output logic [31:0] oTIME_LAP5,
  output logic [31:0] oTIME_LAP6,
  output logic [31:0] oTIME_LAP7,
  output logic [31:0] oTIME_LAP8,
  output logic [31:0] oTIME_LAP9,
  output logic        oRUNNING,
  output logic [3:0]  oLAP_CNT,
  output logic        oLAP_FULL
);

  state_e      state_q;
  logic        running_q;
  logic [31:0] lap_q [LAP_NUM];
  logic [3:0]  lap_cnt_q;
  logic        lap_full_q;
  logic        store_ok;

  stopwatch_time_cnt #(.TICK_DIV(TICK_DIV)) u_time_cnt (
    .iPCLK    (iPCLK),
    .iPRESETn (iPRESETn),
    .run_i    (state_q == ST_RUN),
    .clear_i  (iWATCH_RESET),
    .tick_o   (),
    .time_o   (oCURR_TIME)
  );

  // Run/pause FSM with a registered running flag; reset beats stop beats start.
  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else if (iWATCH_RESET) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (iWATCH_START && !iWATCH_STOP) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (iWATCH_STOP) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Store captures the current (pre-tick) time into the next free slot only.
  assign store_ok = iWATCH_STORE && (state_q != ST_IDLE) && (lap_cnt_q < 4'(LAP_NUM));

  // Lap array and counter; laps are never overwritten until a clear.
  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      // NOTE: the lap array drives output ports directly, so every entry is reset explicitly.
      for (int i = 0; i < LAP_NUM; i++) lap_q[i] <= '0;
      lap_cnt_q  <= '0;
      lap_full_q <= 1'b0;
    end else if (iWATCH_RESET) begin
      for (int i = 0; i < LAP_NUM; i++) lap_q[i] <= '0;
      lap_cnt_q  <= '0;
      lap_full_q <= 1'b0;
    end else if (store_ok) begin
      for (int i = 0; i < LAP_NUM; i++) begin
        if (lap_cnt_q == 4'(i)) lap_q[i] <= oCURR_TIME;
      end
      lap_cnt_q  <= lap_cnt_q + 4'd1;
      lap_full_q <= (lap_cnt_q == 4'(LAP_NUM - 1));
    end
  end

  assign oRUNNING   = running_q;
  assign oLAP_CNT   = lap_cnt_q;
  assign oLAP_FULL  = lap_full_q;
  assign oTIME_LAP0 = lap_q[0];
  assign oTIME_LAP1 = lap_q[1];
  assign oTIME_LAP2 = lap_q[2];
  assign oTIME_LAP3 = lap_q[3];
  assign oTIME_LAP4 = lap_q[4];
  assign oTIME_LAP5 = lap_q[5];
  assign oTIME_LAP6 = lap_q[6];
  assign oTIME_LAP7 = lap_q[7];
  assign oTIME_LAP8 = lap_q[8];
  assign oTIME_LAP9 = lap_q[9];

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Stopwatch timing engine. It sits directly downstream of the APB register interface. It consumes the single-cycle start/stop/reset/store control pulses and produces the running time value plus ten captured lap times. The APB interface reads these back through its CURR_TIME and TIME_LAP0..9 registers. Time is kept as packed binary fields: hours, minutes, seconds, centiseconds.

Parameters:
TICK_DIV, 500000, iPCLK cycles per centisecond (minimum 2; benches use 4)
LAP_NUM, 10, number of lap registers (fixed at 10 to match the register map)

Ports:
iPCLK  in  1  clock
iPRESETn  in  1  asynchronous active-low reset
iWATCH_START  in  1  start/resume pulse
iWATCH_STOP  in  1  pause pulse
iWATCH_RESET  in  1  clear pulse
iWATCH_STORE  in  1  lap-capture pulse
oCURR_TIME  out  32  {hh[31:24], mm[23:16], ss[15:8], cc[7:0]}, each field binary
oTIME_LAP0..oTIME_LAP9  out  32 each  captured lap times, same format
oRUNNING  out  1  high in RUN state
oLAP_CNT  out  4  number of laps stored, 0..10
oLAP_FULL  out  1  high when oLAP_CNT==10

Behaviour:
- Reset and clock: iPRESETn is asynchronous, active-low; iPCLK is the clock. Every register is cleared on reset: all outputs 0, state IDLE, prescaler 0.
- All inputs are sampled on posedge iPCLK. Each cycle an input is high counts as one event.
- States and transitions:
  - IDLE: time is 0.
  - RUN: time advances.
  - PAUSE: time is held.
  - IDLE/PAUSE + start -> RUN.
  - RUN + stop -> PAUSE.
  - Start in RUN and stop in IDLE/PAUSE have no effect.
- Event priority within one cycle: reset > stop > start.
  - Start and stop together: stop wins. From IDLE the block stays IDLE; from RUN it goes to PAUSE.
  - Store is evaluated in parallel with start/stop but is overridden by reset.
- Reset pulse (any state): go to IDLE on the next edge. Clear oCURR_TIME, the prescaler, all laps and oLAP_CNT. oLAP_FULL drops.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while the registered state is RUN; holds its value in PAUSE.
  - Resuming therefore keeps the sub-centisecond phase.
  - It is zeroed only by reset.
  - Tick = prescaler==TICK_DIV-1 while in RUN.
  - First increment occurs TICK_DIV cycles after the edge that entered RUN.
- Time increment on tick (cascaded fields):
  - cc 0..99: at 99 it wraps to 0 and carries.
  - ss 0..59 and mm 0..59: at 59 wrap to 0 and carry.
  - hh 0..99.
  - 99:59:59.99 + tick -> 00:00:00.00. No flag; continues running.
- Tick and stop on the same edge: the increment still happens because it is qualified by the current state. The state then becomes PAUSE.
- Store:
  - Acts in RUN or PAUSE when oLAP_CNT<10: lap[oLAP_CNT] <= oCURR_TIME and oLAP_CNT increments.
  - Captures the pre-increment value if a tick lands on the same edge.
  - Ignored in IDLE and when full. Existing laps are never overwritten.
- Lap outputs are registers. Updates are visible one cycle after the store edge.
- Outputs are glitch-free registered values. The upstream interface may sample them at any time.

Decomposition:
- Package stopwatch_pkg:
  - State encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2.
  - Field limits CC_MAX=99, SS_MAX=59, MM_MAX=59, HH_MAX=99.
  - LAP_NUM=10.
  - Field bit positions of the packed time word.
- Sub-module stopwatch_time_cnt contains the prescaler and cascaded field counters. Its inputs are run, clear and the tick count; its outputs are tick and time[31:0].
- stopwatch_core contains the FSM, lap array and lap counter.

Test Plan:
- Reset: assert iPRESETn low mid-run -> within the same cycle oCURR_TIME=0, all laps 0, oRUNNING=0, oLAP_CNT=0.
- Counting (TICK_DIV=4): start pulse, wait 600 cycles -> oCURR_TIME=32'h0000_0132 (1 s, 50 cc). Continue to 6000 cc (24000 cycles) -> 32'h0001_0000, confirming the minute rollover.
- Pause/resume: start, stop after 10 cycles, idle 100 cycles -> time holds at 32'h0000_0002. Start again -> next increment after 2 cycles, not 4, because prescaler phase is preserved.
- Wrap: force the time register to 32'h633B_3B63 in RUN -> after one tick 32'h0000_0000 and oRUNNING still 1.
- Laps: 11 store pulses spaced 8 cycles apart while running -> lap0..9 hold increasing values 2 cc apart, the 11th is ignored, oLAP_CNT=10 and oLAP_FULL=1. Then a reset pulse -> all laps 0 and oLAP_CNT=0.
- Simultaneous events:
  - start+stop from IDLE -> stays IDLE.
  - reset+store -> laps stay 0.
  - store on a tick edge -> lap equals the pre-tick oCURR_TIME.
